// File: rtl/vec3_stream_master.sv
// Initiator for the three-word vec3 operand/result stream: serialises two
// parallel operand vectors to a wrapper and collects its three result words.
//
// state         | meaning
// S_IDLE        | waiting for start; done pulses here for one cycle after a transaction
// S_WAIT_READY  | operands buffered, waiting for dev_ready
// S_SEND        | seven operand beats (framing a0, then a0 a1 a2 b0 b1 b2)
// S_WAIT_RESULT | waiting for the first result word, timeout down-counter running
// S_COLLECT     | capturing result words c1/c2 on consecutive cycles
// S_ACK         | one-cycle dev_read_done acknowledge
module vec3_stream_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        start,
  input  logic [95:0] vec_a,
  input  logic [95:0] vec_b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [95:0] result_vec,
  input  logic        dev_ready,
  output logic        dev_data_valid,
  output logic [31:0] dev_data,
  input  logic        dev_calc_done,
  input  logic [31:0] dev_result,
  output logic        dev_read_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_READY,
    S_SEND,
    S_WAIT_RESULT,
    S_COLLECT,
    S_ACK
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

  state_t             state;
  logic [5:0][31:0]   ops;
  logic [2:0]         beat;
  logic [1:0]         idx;
  logic [TW-1:0]      tmo_cnt;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state          <= S_IDLE;
      ops            <= '0;
      beat           <= '0;
      idx            <= '0;
      tmo_cnt        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      result_vec     <= '0;
      dev_data_valid <= 1'b0;
      dev_data       <= '0;
      dev_read_done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            ops   <= {vec_b, vec_a};
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= S_WAIT_READY;
          end
        end
        S_WAIT_READY: begin
          if (dev_ready) begin
            state          <= S_SEND;
            beat           <= 3'd0;
            dev_data_valid <= 1'b1;
            dev_data       <= ops[0];
          end
        end
        S_SEND: begin
          if (beat == 3'd6) begin
            state          <= S_WAIT_RESULT;
            dev_data_valid <= 1'b0;
            dev_data       <= '0;
            tmo_cnt        <= TMO_LOAD;
          end else begin
            // beat k+1 carries operand word k, so the framing beat repeats a0
            beat     <= beat + 3'd1;
            dev_data <= ops[beat];
          end
        end
        S_WAIT_RESULT: begin
          if (dev_calc_done) begin
            result_vec[31:0] <= dev_result;
            idx              <= 2'd1;
            state            <= S_COLLECT;
          end else if (TIMEOUT_CYCLES != 0) begin
            if (tmo_cnt == TW'(1)) begin
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt - TW'(1);
            end
          end
        end
        S_COLLECT: begin
          if (dev_calc_done) begin
            if (idx == 2'd1) begin
              result_vec[63:32] <= dev_result;
              idx               <= 2'd2;
            end else begin
              result_vec[95:64] <= dev_result;
              dev_read_done     <= 1'b1;
              state             <= S_ACK;
            end
          end else begin
            // short burst: keep what arrived, flag it, still acknowledge
            err           <= 1'b1;
            dev_read_done <= 1'b1;
            state         <= S_ACK;
          end
        end
        S_ACK: begin
          dev_read_done <= 1'b0;
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec3_stream_master.sv
// Self-checking bench for vec3_stream_master: a behavioural wrapper drives the
// result side while a queue-free reference model predicts beats and results.
module tb_vec3_stream_master;

  localparam int TMO = 8;

  logic        iClk;
  logic        iRst;
  logic        start;
  logic [95:0] vec_a;
  logic [95:0] vec_b;
  logic        busy;
  logic        done;
  logic        err;
  logic [95:0] result_vec;
  logic        dev_ready;
  logic        dev_data_valid;
  logic [31:0] dev_data;
  logic        dev_calc_done;
  logic [31:0] dev_result;
  logic        dev_read_done;

  vec3_stream_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .iClk(iClk), .iRst(iRst), .start(start), .vec_a(vec_a), .vec_b(vec_b),
    .busy(busy), .done(done), .err(err), .result_vec(result_vec),
    .dev_ready(dev_ready), .dev_data_valid(dev_data_valid), .dev_data(dev_data),
    .dev_calc_done(dev_calc_done), .dev_result(dev_result), .dev_read_done(dev_read_done)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int errors = 0;
  int checks = 0;

  logic [95:0] model_res;
  logic [31:0] obs_beats [7];
  bit          obs_dv [7];
  bit          busy_after_start, err_after_start, first_beat_ok;
  bit          dv_after, busy_at_done, err_at_done;
  logic [31:0] data_after;
  logic [95:0] res_at_done;
  int          stall_bad, rd_count, rd_t, done_t;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [31:0] exp_beat(input logic [95:0] a, input logic [95:0] b, input int i);
    logic [191:0] ops;
    ops = {b, a};
    if (i == 0) return a[31:0];
    return ops[32*(i-1) +: 32];
  endfunction

  // Drives one transaction from the current IDLE cycle and records what the DUT did.
  // Returns in the cycle where done is seen (or after the observation window).
  task automatic do_txn(input logic [95:0] a, input logic [95:0] b, input int rdy_dly,
                        input int comp_dly, input int nwords, input logic [95:0] words,
                        input bit start_mid);
    start = 1'b1; vec_a = a; vec_b = b; dev_ready = 1'b0; dev_calc_done = 1'b0;
    tick();
    start = 1'b0;
    vec_a = {$urandom(), $urandom(), $urandom()};
    vec_b = {$urandom(), $urandom(), $urandom()};
    busy_after_start = busy;
    err_after_start  = err;
    stall_bad = 0;
    for (int i = 0; i < rdy_dly; i++) begin
      if (busy !== 1'b1 || dev_data_valid !== 1'b0) stall_bad++;
      tick();
    end
    dev_ready = 1'b1;
    tick();
    dev_ready = 1'b0;
    first_beat_ok = (dev_data_valid === 1'b1);
    for (int i = 0; i < 7; i++) begin
      obs_beats[i] = dev_data;
      obs_dv[i]    = (dev_data_valid === 1'b1);
      start        = start_mid && (i == 3);
      tick();
    end
    start = 1'b0;
    dv_after   = dev_data_valid;
    data_after = dev_data;
    for (int i = 0; i < comp_dly; i++) begin
      dev_result = $urandom();
      tick();
    end
    for (int k = 0; k < nwords; k++) begin
      dev_calc_done = 1'b1;
      dev_result    = words[32*k +: 32];
      tick();
    end
    dev_calc_done = 1'b0;
    dev_result    = $urandom();
    rd_count = 0; rd_t = -1; done_t = -1;
    for (int t = 0; t < 40; t++) begin
      if (dev_read_done === 1'b1) begin
        rd_count++;
        if (rd_t < 0) rd_t = t;
      end
      if (done === 1'b1) begin
        done_t = t;
        break;
      end
      tick();
    end
    err_at_done  = err;
    res_at_done  = result_vec;
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    iRst = 1'b1; start = 1'b0; vec_a = '0; vec_b = '0;
    dev_ready = 1'b0; dev_calc_done = 1'b0; dev_result = '0;
    tick(); tick();
    checks++;
    if ({busy, done, err, dev_data_valid, dev_read_done} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {busy, done, err, dev_data_valid, dev_read_done});
    end
    checks++;
    if (dev_data !== 32'h0 || result_vec !== 96'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h want 0/0", dev_data, result_vec);
    end
    iRst = 1'b0;
    model_res = '0;
    tick();
  endtask

  task automatic test_basic();
    logic [95:0] a, b, w;
    a = {32'h0, 32'h0, 32'h3F800000};
    b = {32'h0, 32'h3F800000, 32'h0};
    w = {32'h3F800000, 32'h0, 32'h0};
    do_txn(a, b, 0, 0, 3, w, 1'b0);
    model_res = w;
    checks++;
    if (busy_after_start !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_after_start); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (!obs_dv[i] || obs_beats[i] !== exp_beat(a, b, i)) begin
        errors++; $display("FAIL basic_beat%0d: got %h (valid %0d) want %h", i, obs_beats[i], obs_dv[i], exp_beat(a, b, i));
      end
    end
    checks++;
    if (dv_after !== 1'b0 || data_after !== 32'h0) begin
      errors++; $display("FAIL basic_send_end: got valid %b data %h want 0/0", dv_after, data_after);
    end
    checks++;
    if (rd_count != 1 || rd_t != 0) begin errors++; $display("FAIL basic_read_done: got count %0d at %0d want 1 at 0", rd_count, rd_t); end
    checks++;
    if (done_t != 1) begin errors++; $display("FAIL basic_done_time: got %0d want 1", done_t); end
    checks++;
    if (res_at_done !== model_res) begin errors++; $display("FAIL basic_result: got %h want %h", res_at_done, model_res); end
    checks++;
    if (err_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL basic_err_busy: got err %b busy %b want 0/0", err_at_done, busy_at_done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got done %b busy %b want 0/0", done, busy); end
  endtask

  task automatic test_ready_stall();
    logic [95:0] a, b, w;
    a = {$urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom()};
    w = {$urandom(), $urandom(), $urandom()};
    do_txn(a, b, 20, 2, 3, w, 1'b0);
    model_res = w;
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", stall_bad); end
    checks++;
    if (!first_beat_ok) begin errors++; $display("FAIL stall_first_beat: got valid 0 want 1"); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (!obs_dv[i] || obs_beats[i] !== exp_beat(a, b, i)) begin
        errors++; $display("FAIL stall_beat%0d: got %h want %h", i, obs_beats[i], exp_beat(a, b, i));
      end
    end
    checks++;
    if (res_at_done !== model_res || done_t != 1) begin
      errors++; $display("FAIL stall_result: got %h at %0d want %h at 1", res_at_done, done_t, model_res);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_txn({$urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom()}, 0, 0, 0, '0, 1'b0);
    checks++;
    if (done_t != TMO) begin errors++; $display("FAIL timeout_time: got %0d want %0d", done_t, TMO); end
    checks++;
    if (err_at_done !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err_at_done); end
    checks++;
    if (rd_count != 0) begin errors++; $display("FAIL timeout_read_done: got %0d want 0", rd_count); end
    checks++;
    if (res_at_done !== model_res) begin errors++; $display("FAIL timeout_result: got %h want %h", res_at_done, model_res); end
    tick();
  endtask

  task automatic test_short_burst();
    logic [95:0] w;
    w = {32'hDEADBEEF, 32'h22222222, 32'h11111111};
    do_txn({$urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom()}, 1, 1, 2, w, 1'b0);
    model_res[63:0] = w[63:0];
    checks++;
    if (res_at_done !== model_res) begin errors++; $display("FAIL short_result: got %h want %h", res_at_done, model_res); end
    checks++;
    if (err_at_done !== 1'b1) begin errors++; $display("FAIL short_err: got %b want 1", err_at_done); end
    checks++;
    if (rd_count != 1 || rd_t != 1 || done_t != 2) begin
      errors++; $display("FAIL short_timing: got rd %0d at %0d done %0d want 1 at 1 done 2", rd_count, rd_t, done_t);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [95:0] a, b, w;
    a = {$urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom()};
    w = {$urandom(), $urandom(), $urandom()};
    do_txn(a, b, 0, 0, 2, w, 1'b1);
    model_res[63:0] = w[63:0];
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (!obs_dv[i] || obs_beats[i] !== exp_beat(a, b, i)) begin
        errors++; $display("FAIL midstart_beat%0d: got %h want %h", i, obs_beats[i], exp_beat(a, b, i));
      end
    end
    checks++;
    if (done_t != 2 || err_at_done !== 1'b1 || res_at_done !== model_res) begin
      errors++; $display("FAIL midstart_txn: got done %0d err %b res %h want 2/1/%h", done_t, err_at_done, res_at_done, model_res);
    end
    a = {$urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom()};
    w = {$urandom(), $urandom(), $urandom()};
    do_txn(a, b, 0, 1, 3, w, 1'b0);
    model_res = w;
    checks++;
    if (busy_after_start !== 1'b1 || err_after_start !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: got busy %b err %b want 1/0", busy_after_start, err_after_start);
    end
    checks++;
    if (obs_beats[6] !== b[95:64] || res_at_done !== model_res || err_at_done !== 1'b0) begin
      errors++; $display("FAIL b2b_txn: got beat6 %h res %h err %b want %h/%h/0", obs_beats[6], res_at_done, err_at_done, b[95:64], model_res);
    end
    tick();
  endtask

  task automatic test_reset_collect();
    int rd_seen;
    start = 1'b1; vec_a = {$urandom(), $urandom(), $urandom()}; vec_b = vec_a;
    tick();
    start = 1'b0; dev_ready = 1'b1;
    tick();
    dev_ready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    dev_calc_done = 1'b1; dev_result = 32'hA5A5A5A5;
    tick();
    dev_result = 32'h5A5A5A5A; iRst = 1'b1;
    tick();
    iRst = 1'b0; dev_calc_done = 1'b0;
    model_res = '0;
    checks++;
    if ({busy, done, err, dev_data_valid, dev_read_done} !== 5'b0 || dev_data !== 32'h0 || result_vec !== 96'h0) begin
      errors++; $display("FAIL rstcol_outputs: got %b %h %h want all 0",
                         {busy, done, err, dev_data_valid, dev_read_done}, dev_data, result_vec);
    end
    rd_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (dev_read_done === 1'b1 || busy === 1'b1 || done === 1'b1) rd_seen++;
      tick();
    end
    checks++;
    if (rd_seen != 0) begin errors++; $display("FAIL rstcol_idle: got %0d active cycles want 0", rd_seen); end
    do_txn({$urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom()}, 0, 0, 3, 96'h3_00000002_00000001, 1'b0);
    model_res = 96'h3_00000002_00000001;
    checks++;
    if (done_t != 1 || res_at_done !== model_res) begin
      errors++; $display("FAIL rstcol_recover: got done %0d res %h want 1/%h", done_t, res_at_done, model_res);
    end
    tick();
  endtask

  task automatic test_random();
    logic [95:0] a, b, w;
    int nw, rdly, cdly, exp_done;
    for (int n = 0; n < 8; n++) begin
      a = {$urandom(), $urandom(), $urandom()};
      b = {$urandom(), $urandom(), $urandom()};
      w = {$urandom(), $urandom(), $urandom()};
      rdly = $urandom_range(0, 5);
      cdly = $urandom_range(0, 5);
      nw   = $urandom_range(1, 3);
      do_txn(a, b, rdly, cdly, nw, w, 1'b0);
      for (int k = 0; k < nw; k++) model_res[32*k +: 32] = w[32*k +: 32];
      exp_done = (nw == 3) ? 1 : 2;
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (!obs_dv[i] || obs_beats[i] !== exp_beat(a, b, i)) begin
          errors++; $display("FAIL rand%0d_beat%0d: got %h want %h", n, i, obs_beats[i], exp_beat(a, b, i));
        end
      end
      checks++;
      if (res_at_done !== model_res || err_at_done !== (nw != 3) || done_t != exp_done || rd_count != 1) begin
        errors++; $display("FAIL rand%0d_txn: got res %h err %b done %0d rd %0d want %h/%0d/%0d/1",
                           n, res_at_done, err_at_done, done_t, rd_count, model_res, (nw != 3), exp_done);
      end
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ready_stall();
    test_timeout();
    test_short_burst();
    test_back_to_back();
    test_reset_collect();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
